frame_sequencer: RTL and testbench

Frame counter and clock generator for the APU channels (pulse, and later triangle/noise). It derives the CPU tick from the system clock and toggles apu_clk every CPU tick. It emits quarter-frame and half-frame strobes in 4-step or 5-step mode, and raises the frame IRQ. It is configured by writes to the $4017-equivalent register, and its outputs drive the channel clock inputs in_apu_clk, in_qfr_clk and in_hfr_clk.

---
 rtl/apu_pkg.sv | 20 ++
 rtl/tick_divider.sv | 24 ++
 rtl/frame_sequencer.sv | 129 ++++++++++++
 tb/tb_frame_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU definitions: default NTSC frame-step tick counts, the
// frame-counter mode encoding and the bit positions of the $4017-style
// frame-counter register.
package apu_pkg;

  localparam int STEP1_NTSC = 7457;
  localparam int STEP2_NTSC = 14913;
  localparam int STEP3_NTSC = 22371;
  localparam int STEP4_NTSC = 29829;
  localparam int STEP5_NTSC = 37281;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } mode_e;

  localparam int FC_MODE_BIT    = 7;
  localparam int FC_INHIBIT_BIT = 6;

endpackage

// File: rtl/tick_divider.sv
// Prescaler that turns the system clock into a one-clk CPU tick enable.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   tick     : high in the clk where the prescaler sits at PRESCALE-1
module tick_divider #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre;

  assign tick = (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) pre <= '0;
    else     pre <= tick ? '0 : pre + 1'b1;
  end

endmodule

// File: rtl/frame_sequencer.sv
// APU frame counter: derives apu_clk from the CPU tick, sequences the
// quarter/half-frame strobes in 4-step or 5-step mode and raises frame_irq.
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   wr_en, wr_data     : frame-counter register write (bit7 mode, bit6 inhibit)
//   irq_ack            : clears frame_irq
//   apu_clk            : toggles every CPU tick
//   qfr_clk, hfr_clk   : one-clk quarter/half-frame strobes
//   frame_irq          : frame interrupt level
//   mode, step         : current mode, last step executed (0 after reload)
module frame_sequencer
  import apu_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 16,
  parameter int STEP1    = STEP1_NTSC,
  parameter int STEP2    = STEP2_NTSC,
  parameter int STEP3    = STEP3_NTSC,
  parameter int STEP4    = STEP4_NTSC,
  parameter int STEP5    = STEP5_NTSC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_ack,
  output logic       apu_clk,
  output logic       qfr_clk,
  output logic       hfr_clk,
  output logic       frame_irq,
  output logic       mode,
  output logic [2:0] step
);

  logic             tick;
  mode_e            mode_q;
  logic             inhibit_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       step_d;
  logic             qfr_d, hfr_d, irq_set;
  logic             unused_wr_bits;

  assign unused_wr_bits = ^wr_data[5:0];
  assign cnt_inc        = cnt_q + 1'b1;
  assign mode           = mode_q;

  tick_divider #(.PRESCALE(PRESCALE)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Step decode for this tick. A pending reload takes priority over any
  // step match, so a reload landing on a step swallows that step's strobe/IRQ.
  always_comb begin
    cnt_d   = cnt_q;
    step_d  = step;
    qfr_d   = 1'b0;
    hfr_d   = 1'b0;
    irq_set = 1'b0;
    if (tick) begin
      cnt_d = cnt_inc;
      if (pend_q) begin
        cnt_d  = '0;
        step_d = 3'd0;
        qfr_d  = (mode_q == MODE_5STEP);
        hfr_d  = (mode_q == MODE_5STEP);
      end else if (cnt_inc == CNT_W'(STEP1)) begin
        step_d = 3'd1;
        qfr_d  = 1'b1;
      end else if (cnt_inc == CNT_W'(STEP2)) begin
        step_d = 3'd2;
        qfr_d  = 1'b1;
        hfr_d  = 1'b1;
      end else if (cnt_inc == CNT_W'(STEP3)) begin
        step_d = 3'd3;
        qfr_d  = 1'b1;
      end else if (cnt_inc == CNT_W'(STEP4)) begin
        step_d = 3'd4;
        // In 5-step mode step 4 is silent and the frame keeps counting.
        if (mode_q == MODE_4STEP) begin
          qfr_d   = 1'b1;
          hfr_d   = 1'b1;
          irq_set = !inhibit_q;
          cnt_d   = '0;
        end
      end else if (mode_q == MODE_5STEP && cnt_inc == CNT_W'(STEP5)) begin
        step_d = 3'd5;
        qfr_d  = 1'b1;
        hfr_d  = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      apu_clk   <= 1'b0;
      qfr_clk   <= 1'b0;
      hfr_clk   <= 1'b0;
      frame_irq <= 1'b0;
      mode_q    <= MODE_4STEP;
      inhibit_q <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      step      <= 3'd0;
    end else begin
      apu_clk <= apu_clk ^ tick;
      qfr_clk <= qfr_d;
      hfr_clk <= hfr_d;
      cnt_q   <= cnt_d;
      step    <= step_d;
      // A write on the reload tick re-arms the reload for the next tick.
      if (wr_en) begin
        mode_q    <= mode_e'(wr_data[FC_MODE_BIT]);
        inhibit_q <= wr_data[FC_INHIBIT_BIT];
        pend_q    <= 1'b1;
      end else if (tick) begin
        pend_q    <= 1'b0;
      end
      // Inhibit write beats a set; a set beats an acknowledge.
      if (wr_en && wr_data[FC_INHIBIT_BIT]) frame_irq <= 1'b0;
      else if (irq_set)                     frame_irq <= 1'b1;
      else if (irq_ack)                     frame_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Three instances: 0 = NTSC defaults, 1 = short steps, 2 = short steps with
// PRESCALE=4. Expected strobes are queued per instance and matched at negedge.
module tb_frame_sequencer;

  localparam int S1 = 10, S2 = 20, S3 = 30, S4 = 40, S5 = 50;

  typedef struct {
    int cyc;
    bit q;
    bit h;
  } ev_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [2:0] rst = 3'b111;
  logic [2:0] wr_en = 3'b000;
  logic [2:0] irq_ack = 3'b000;
  logic [7:0] wd [3];
  logic [2:0] apu, qfr, hfr, irq, mode;
  logic [2:0] stp [3];

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_sequencer u_dut0 (
    .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_data(wd[0]), .irq_ack(irq_ack[0]),
    .apu_clk(apu[0]), .qfr_clk(qfr[0]), .hfr_clk(hfr[0]), .frame_irq(irq[0]),
    .mode(mode[0]), .step(stp[0]));

  frame_sequencer #(.PRESCALE(1), .CNT_W(8), .STEP1(S1), .STEP2(S2), .STEP3(S3),
                    .STEP4(S4), .STEP5(S5)) u_dut1 (
    .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_data(wd[1]), .irq_ack(irq_ack[1]),
    .apu_clk(apu[1]), .qfr_clk(qfr[1]), .hfr_clk(hfr[1]), .frame_irq(irq[1]),
    .mode(mode[1]), .step(stp[1]));

  frame_sequencer #(.PRESCALE(4), .CNT_W(8), .STEP1(S1), .STEP2(S2), .STEP3(S3),
                    .STEP4(S4), .STEP5(S5)) u_dut2 (
    .clk(clk), .rst(rst[2]), .wr_en(wr_en[2]), .wr_data(wd[2]), .irq_ack(irq_ack[2]),
    .apu_clk(apu[2]), .qfr_clk(qfr[2]), .hfr_clk(hfr[2]), .frame_irq(irq[2]),
    .mode(mode[2]), .step(stp[2]));

  // ---------------- scoreboard ----------------
  task automatic push(input int d, input int c, input bit q, input bit h);
    ev_t e;
    e.cyc = c; e.q = q; e.h = h;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int d, input logic q, input logic h);
    ev_t e;
    bit  got;
    if (q === 1'b1 || h === 1'b1) begin
      got = 1'b1;
      case (d)
        0: if (q0.size() > 0) e = q0.pop_front(); else got = 1'b0;
        1: if (q1.size() > 0) e = q1.pop_front(); else got = 1'b0;
        default: if (q2.size() > 0) e = q2.pop_front(); else got = 1'b0;
      endcase
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL strobe[%0d] unexpected at cyc %0d: got q=%0b h=%0b, expected none", d, cyc, q, h);
      end else if (e.cyc != cyc || e.q !== q || e.h !== h) begin
        errors++;
        $display("FAIL strobe[%0d]: got q=%0b h=%0b at cyc %0d, expected q=%0b h=%0b at cyc %0d",
                 d, q, h, cyc, e.q, e.h, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, qfr[0], hfr[0]);
    mon(1, qfr[1], hfr[1]);
    mon(2, qfr[2], hfr[2]);
  end

  task automatic drain(input int d);
    int n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL drain[%0d]: %0d expected strobes never seen, expected 0", d, n);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Returns with cyc = index of the reset edge; tick k lands on edge base+k*PRESCALE.
  task automatic do_reset(input int d, output int base);
    @(negedge clk);
    rst[d] = 1'b1; wr_en[d] = 1'b0; irq_ack[d] = 1'b0; wd[d] = 8'h00;
    @(negedge clk);
    rst[d] = 1'b0;
    base = cyc;
  endtask

  task automatic park(input int d);
    rst[d] = 1'b1;
  endtask

  // Write sampled on edge 'at'; returns at the negedge after that edge.
  task automatic wr(input int d, input int at, input logic [7:0] data);
    wait_to(at - 1);
    wr_en[d] = 1'b1; wd[d] = data;
    @(negedge clk);
    wr_en[d] = 1'b0;
  endtask

  task automatic ack(input int d, input int at);
    wait_to(at - 1);
    irq_ack[d] = 1'b1;
    @(negedge clk);
    irq_ack[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    wd[0] = 8'h00; wd[1] = 8'h00; wd[2] = 8'h00;
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({apu[d], qfr[d], hfr[d], irq[d], mode[d], stp[d]} !== 8'h00) begin
        errors++;
        $display("FAIL reset[%0d]: got %b, expected 00000000", d,
                 {apu[d], qfr[d], hfr[d], irq[d], mode[d], stp[d]});
      end
    end
  endtask

  task automatic test_four_step();
    int b;
    do_reset(0, b);
    push(0, b + 7457, 1, 0);
    push(0, b + 14913, 1, 1);
    push(0, b + 22371, 1, 0);
    push(0, b + 29829, 1, 1);
    push(0, b + 29829 + 7457, 1, 0);
    wait_to(b + 29828);
    checks++;
    if (irq[0] !== 1'b0 || stp[0] !== 3'd3) begin
      errors++;
      $display("FAIL four_pre_irq: got irq=%0b step=%0d, expected irq=0 step=3", irq[0], stp[0]);
    end
    wait_to(b + 29829);
    checks++;
    if (irq[0] !== 1'b1 || stp[0] !== 3'd4 || mode[0] !== 1'b0) begin
      errors++;
      $display("FAIL four_irq: got irq=%0b step=%0d mode=%0b, expected irq=1 step=4 mode=0",
               irq[0], stp[0], mode[0]);
    end
    wait_to(b + 29829 + 7457 + 3);
    checks++;
    if (irq[0] !== 1'b1 || stp[0] !== 3'd1) begin
      errors++;
      $display("FAIL four_wrap: got irq=%0b step=%0d, expected irq=1 step=1", irq[0], stp[0]);
    end
    drain(0);
    park(0);
  endtask

  task automatic test_five_step();
    int b, r;
    do_reset(1, b);
    wr(1, b + 5, 8'h80);
    r = b + 6;
    push(1, r, 1, 1);
    push(1, r + S1, 1, 0);
    push(1, r + S2, 1, 1);
    push(1, r + S3, 1, 0);
    push(1, r + S5, 1, 1);
    push(1, r + S5 + S1, 1, 0);
    wait_to(r);
    checks++;
    if (mode[1] !== 1'b1 || stp[1] !== 3'd0) begin
      errors++;
      $display("FAIL five_reload: got mode=%0b step=%0d, expected mode=1 step=0", mode[1], stp[1]);
    end
    wait_to(r + S4);
    checks++;
    if (stp[1] !== 3'd4 || irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL five_step4: got step=%0d irq=%0b, expected step=4 irq=0", stp[1], irq[1]);
    end
    wait_to(r + S5);
    checks++;
    if (stp[1] !== 3'd5 || irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL five_step5: got step=%0d irq=%0b, expected step=5 irq=0", stp[1], irq[1]);
    end
    wait_to(r + S5 + S1 + 2);
    drain(1);
    park(1);
  endtask

  task automatic test_irq_inhibit();
    int b, r, r2;
    do_reset(1, b);
    push(1, b + S1, 1, 0); push(1, b + S2, 1, 1); push(1, b + S3, 1, 0); push(1, b + S4, 1, 1);
    wait_to(b + S4);
    checks++;
    if (irq[1] !== 1'b1) begin
      errors++;
      $display("FAIL inh_set: got irq=%0b, expected 1", irq[1]);
    end
    wr(1, b + 45, 8'h40);
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL inh_clear: got irq=%0b, expected 0", irq[1]);
    end
    r = b + 46;
    push(1, r + S1, 1, 0); push(1, r + S2, 1, 1); push(1, r + S3, 1, 0); push(1, r + S4, 1, 1);
    wait_to(r + S4 + 1);
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL inh_noirq: got irq=%0b, expected 0", irq[1]);
    end
    wr(1, r + 42, 8'h00);
    r2 = r + 43;
    push(1, r2 + S1, 1, 0); push(1, r2 + S2, 1, 1); push(1, r2 + S3, 1, 0); push(1, r2 + S4, 1, 1);
    wait_to(r2 + S4);
    checks++;
    if (irq[1] !== 1'b1) begin
      errors++;
      $display("FAIL uninh_set: got irq=%0b, expected 1", irq[1]);
    end
    ack(1, r2 + 45);
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: got irq=%0b, expected 0", irq[1]);
    end
    drain(1);
    park(1);
  endtask

  task automatic test_irq_collide();
    int b;
    do_reset(1, b);
    push(1, b + S1, 1, 0); push(1, b + S2, 1, 1); push(1, b + S3, 1, 0); push(1, b + S4, 1, 1);
    ack(1, b + S4);
    checks++;
    if (irq[1] !== 1'b1) begin
      errors++;
      $display("FAIL set_vs_ack: got irq=%0b, expected 1", irq[1]);
    end
    ack(1, b + 50);
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL ack_only: got irq=%0b, expected 0", irq[1]);
    end
    push(1, b + 40 + S1, 1, 0); push(1, b + 40 + S2, 1, 1);
    push(1, b + 40 + S3, 1, 0); push(1, b + 40 + S4, 1, 1);
    wr(1, b + 80, 8'h40);
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL set_vs_inhibit: got irq=%0b, expected 0", irq[1]);
    end
    wait_to(b + 85);
    checks++;
    if (stp[1] !== 3'd4 - 3'd4 || irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL collide_reload: got step=%0d irq=%0b, expected step=0 irq=0", stp[1], irq[1]);
    end
    drain(1);
    park(1);
  endtask

  task automatic test_coincide();
    int b;
    do_reset(1, b);
    wr(1, b + S1 - 1, 8'h00);
    wait_to(b + S1);
    checks++;
    if (qfr[1] !== 1'b0 || stp[1] !== 3'd0) begin
      errors++;
      $display("FAIL coincide: got qfr=%0b step=%0d, expected qfr=0 step=0", qfr[1], stp[1]);
    end
    push(1, b + S1 + S1, 1, 0);
    push(1, b + S1 + S2, 1, 1);
    wait_to(b + S1 + S2 + 2);
    drain(1);
    park(1);
  endtask

  task automatic test_prescale();
    int b;
    do_reset(2, b);
    push(2, b + 4 * S1, 1, 0);
    push(2, b + 4 * S2, 1, 1);
    for (int c = 0; c < 24; c++) begin
      wait_to(b + c);
      checks++;
      if (apu[2] !== 1'(((c / 4) % 2))) begin
        errors++;
        $display("FAIL apu_clk @%0d: got %0b, expected %0b", c, apu[2], 1'(((c / 4) % 2)));
      end
    end
    wait_to(b + 4 * S1);
    checks++;
    if (qfr[2] !== 1'b1) begin
      errors++;
      $display("FAIL ps_qfr_hi: got %0b, expected 1", qfr[2]);
    end
    wait_to(b + 4 * S1 + 1);
    checks++;
    if (qfr[2] !== 1'b0) begin
      errors++;
      $display("FAIL ps_qfr_width: got %0b, expected 0", qfr[2]);
    end
    wait_to(b + 101);
    checks++;
    if (stp[2] !== 3'd2 || apu[2] !== 1'b1) begin
      errors++;
      $display("FAIL ps_midframe: got step=%0d apu=%0b, expected step=2 apu=1", stp[2], apu[2]);
    end
    rst[2] = 1'b1;
    @(negedge clk);
    checks++;
    if ({apu[2], qfr[2], hfr[2], irq[2], mode[2], stp[2]} !== 8'h00) begin
      errors++;
      $display("FAIL ps_reset: got %b, expected 00000000",
               {apu[2], qfr[2], hfr[2], irq[2], mode[2], stp[2]});
    end
    drain(2);
    park(2);
  endtask

  initial begin
    test_reset();
    test_four_step();
    test_five_step();
    test_irq_inhibit();
    test_irq_collide();
    test_coincide();
    test_prescale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
